// File: rtl/sw_debounce_if.sv
// Switch-side bus for sw_debounce: raw pins in, debounced levels and pulses out.
// rise_out/fall_out exist only when SW_DEBOUNCE_EDGE_EN is defined.
interface sw_debounce_if #(
   parameter int WIDTH = 8
);
   logic [0:WIDTH-1] sw_in;
   logic [0:WIDTH-1] db_out;
   logic             change_out;
`ifdef SW_DEBOUNCE_EDGE_EN
   logic [0:WIDTH-1] rise_out;
   logic [0:WIDTH-1] fall_out;
`endif

   modport master (
      output sw_in,
`ifdef SW_DEBOUNCE_EDGE_EN
      input  rise_out,
      input  fall_out,
`endif
      input  db_out,
      input  change_out
   );

   modport slave (
      input  sw_in,
`ifdef SW_DEBOUNCE_EDGE_EN
      output rise_out,
      output fall_out,
`endif
      output db_out,
      output change_out
   );
endinterface

// File: rtl/sw_debounce.sv
// Per-bit synchronizer and counting debouncer for the board slide switches.
// Optional macro SW_DEBOUNCE_EDGE_EN adds registered per-bit rise/fall pulses.
module sw_debounce #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_MAX     = 1000000
) (
   input  logic         clk_100_in,
   input  logic         rst_in,
   sw_debounce_if.slave sw_bus
);
   localparam int            CW       = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

   typedef enum logic {IDLE = 1'b0, CHECK = 1'b1} state_t;

   logic [0:WIDTH-1] db_vec;
   logic [0:WIDTH-1] toggle_vec;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic [SYNC_STAGES-1:0] sync_q, sync_d;
         logic                   sync_bit;
         state_t                 state_q, state_d;
         logic [CW-1:0]          cnt_q, cnt_d;
         logic                   db_q, db_d;

         assign sync_d   = {sync_q[SYNC_STAGES-2:0], sw_bus.sw_in[gi]};
         assign sync_bit = sync_q[SYNC_STAGES-1];

         always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            db_d    = db_q;
            case (state_q)
               IDLE: begin
                  if (sync_bit != db_q) begin
                     // A one-cycle qualification accepts the new level immediately.
                     if (CNT_MAX == 1) begin
                        db_d = ~db_q;
                     end else begin
                        state_d = CHECK;
                        cnt_d   = CW'(1);
                     end
                  end
               end
               CHECK: begin
                  if (sync_bit == db_q) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else if (cnt_q == CNT_LAST) begin
                     db_d    = ~db_q;
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               default: begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            endcase
         end

         always_ff @(posedge clk_100_in or posedge rst_in) begin
            if (rst_in) begin
               sync_q  <= '0;
               state_q <= IDLE;
               cnt_q   <= '0;
               db_q    <= 1'b0;
            end else begin
               sync_q  <= sync_d;
               state_q <= state_d;
               cnt_q   <= cnt_d;
               db_q    <= db_d;
            end
         end

         assign db_vec[gi]     = db_q;
         assign toggle_vec[gi] = db_d ^ db_q;
      end
   endgenerate

   // Pulses are registered alongside db so they line up with the new level.
   logic change_q, change_d;
   assign change_d = |toggle_vec;

`ifdef SW_DEBOUNCE_EDGE_EN
   logic [0:WIDTH-1] rise_q, rise_d;
   logic [0:WIDTH-1] fall_q, fall_d;
   assign rise_d = toggle_vec & ~db_vec;
   assign fall_d = toggle_vec & db_vec;

   always_ff @(posedge clk_100_in or posedge rst_in) begin
      if (rst_in) begin
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign sw_bus.rise_out = rise_q;
   assign sw_bus.fall_out = fall_q;
`endif

   always_ff @(posedge clk_100_in or posedge rst_in) begin
      if (rst_in) begin
         change_q <= 1'b0;
      end else begin
         change_q <= change_d;
      end
   end

   assign sw_bus.db_out     = db_vec;
   assign sw_bus.change_out = change_q;
endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce (WIDTH=8, SYNC_STAGES=2, CNT_MAX=4).
// Expected toggles are queued at stimulus time and popped on each change_out pulse.
module tb_sw_debounce;
   localparam int W   = 8;
   localparam int SS  = 2;
   localparam int CM  = 4;
   localparam int LAT = SS + CM - 1;

   typedef struct {
      int         cyc;
      logic [0:W-1] db;
      logic [0:W-1] rise;
      logic [0:W-1] fall;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t sb_q[$];
   exp_t mon_e;

   sw_debounce_if #(.WIDTH(W)) sw_bus ();

   sw_debounce #(
      .WIDTH(W),
      .SYNC_STAGES(SS),
      .CNT_MAX(CM)
   ) dut (
      .clk_100_in(clk),
      .rst_in(rst),
      .sw_bus(sw_bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_exp(input int e_cyc, input logic [0:W-1] db,
                           input logic [0:W-1] rise, input logic [0:W-1] fall);
      exp_t e;
      e.cyc  = e_cyc;
      e.db   = db;
      e.rise = rise;
      e.fall = fall;
      sb_q.push_back(e);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (sb_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      check_eq("drain_pending", sb_q.size(), 0);
   endtask

   // Monitor: each change_out pulse must match the oldest queued toggle.
   always @(negedge clk) begin
      if (sw_bus.change_out === 1'b1) begin
         if (sb_q.size() == 0) begin
            check_eq("spurious_change", 1, 0);
         end else begin
            mon_e = sb_q.pop_front();
            $display("[TB] change at cycle %0d db=%h", cyc, sw_bus.db_out);
            check_eq("change_cyc", cyc, mon_e.cyc);
            check_eq("change_db", sw_bus.db_out, mon_e.db);
`ifdef SW_DEBOUNCE_EDGE_EN
            check_eq("rise", sw_bus.rise_out, mon_e.rise);
            check_eq("fall", sw_bus.fall_out, mon_e.fall);
`endif
         end
      end
   end

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int           e;
      logic [0:W-1] pat;
      pat = 8'b11101111;

      // Reset held with all switches high.
      sw_bus.sw_in = 8'hFF;
      repeat (4) begin
         @(negedge clk);
         check_eq("rst_db", sw_bus.db_out, 0);
         check_eq("rst_change", sw_bus.change_out, 0);
`ifdef SW_DEBOUNCE_EDGE_EN
         check_eq("rst_rise", sw_bus.rise_out, 0);
         check_eq("rst_fall", sw_bus.fall_out, 0);
`endif
      end
      sw_bus.sw_in = 8'h00;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("idle_db", sw_bus.db_out, 0);

      // Clean press on bit 3.
      sw_bus.sw_in = 8'h10;
      e = cyc + 1;
      push_exp(e + LAT, 8'h10, 8'h10, 8'h00);
      repeat (LAT) @(negedge clk);
      check_eq("press_early", sw_bus.db_out, 8'h00);
      drain(20);

      // Bounce on bit 0: glitch low at the fourth sample restarts the count.
      e = cyc + 1;
      push_exp(e + 9, 8'h90, 8'h80, 8'h00);
      for (int k = 0; k < 8; k++) begin
         sw_bus.sw_in = pat[k] ? 8'h90 : 8'h10;
         @(negedge clk);
         check_eq("bounce_hold", sw_bus.db_out, 8'h10);
      end
      @(negedge clk);
      check_eq("bounce_early", sw_bus.db_out, 8'h10);
      drain(20);

      // Both held bits released together.
      sw_bus.sw_in = 8'h00;
      e = cyc + 1;
      push_exp(e + LAT, 8'h00, 8'h00, 8'h90);
      drain(20);

      // Simultaneous press on bits 0 and 7.
      sw_bus.sw_in = 8'h81;
      e = cyc + 1;
      push_exp(e + LAT, 8'h81, 8'h81, 8'h00);
      repeat (LAT) @(negedge clk);
      check_eq("simul_early", sw_bus.db_out, 8'h00);
      drain(20);

      // Release bit 7 only.
      sw_bus.sw_in = 8'h80;
      e = cyc + 1;
      push_exp(e + LAT, 8'h80, 8'h00, 8'h01);
      repeat (LAT) @(negedge clk);
      check_eq("release_early", sw_bus.db_out, 8'h81);
      drain(20);
      check_eq("release_bit0_kept", sw_bus.db_out, 8'h80);

      // Reset asserted between edges while bit 5 is mid-count.
      sw_bus.sw_in = 8'h84;
      e = cyc + 1;
      repeat (4) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check_eq("midrst_db", sw_bus.db_out, 8'h00);
      check_eq("midrst_change", sw_bus.change_out, 0);
      repeat (2) @(negedge clk);
      check_eq("midrst_hold_db", sw_bus.db_out, 8'h00);
      rst = 1'b0;
      e = cyc + 1;
      push_exp(e + LAT, 8'h84, 8'h84, 8'h00);
      repeat (LAT) @(negedge clk);
      check_eq("midrst_early", sw_bus.db_out, 8'h00);
      drain(20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
